// File: rtl/pb_group_blank_ctrl.sv
// Push-button front end: per-button synchronizer, debouncer and blank action,
// producing the four LED group blank controls.

module pb_group_blank_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TOGGLE_MODE     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clear_all,
    output logic blank,
    output logic press,
    output logic btn_db
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          blank_q, blank_d;
    logic          rise;

    always_comb begin
        s1_d    = btn;
        s2_d    = s1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        rise    = 1'b0;

        // Any return to the accepted level restarts the window; the counter
        // stops at CNT_MAX because acceptance clears it on that same cycle.
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        rise    = ~db_q & db_d;
        press_d = rise;

        if (clear_all) begin
            blank_d = 1'b0;
        end else if (TOGGLE_MODE != 0) begin
            if (rise) blank_d = ~blank_q;
        end else begin
            blank_d = db_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            blank_q <= blank_d;
        end
    end

    assign blank  = blank_q;
    assign press  = press_q;
    assign btn_db = db_q;
endmodule

module pb_group_blank_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TOGGLE_MODE     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       clear_all,
    output logic [3:0] blank,
    output logic [3:0] press,
    output logic [3:0] btn_db
);
    localparam int NUM_LANES = 4;

    // Channels share nothing but clock, reset and clear_all.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_chan
        pb_group_blank_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .TOGGLE_MODE    (TOGGLE_MODE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .btn      (btn[k]),
            .clear_all(clear_all),
            .blank    (blank[k]),
            .press    (press[k]),
            .btn_db   (btn_db[k])
        );
    end
endmodule
